mio_wait_ctrl: RTL and testbench
================================

Name: mio_wait_ctrl

Overview:
Bus wait-state controller between the multi-cycle CPU and the MIO bus. It watches each CPU memory/IO request (CPU_MIO, mem_w, addr_bus) and inserts a region-dependent number of wait cycles. It then returns a one-cycle MIO_ready pulse to the CPU. This replaces the button-driven MIO_ready in the top level and gives block RAM and peripherals deterministic access latency.

Parameters:
RAM_WAIT, 2, wait cycles for RAM region (addr[31:28] not E/F); range 0-15
SEG_WAIT, 1, wait cycles for 7-seg region (addr[31:28]==4'hE)
GPIO_WAIT, 1, wait cycles for LED/GPIO region (addr[31:28]==4'hF, addr[2]==0)
CNT_WAIT, 3, wait cycles for counter region (addr[31:28]==4'hF, addr[2]==1)

Ports:
clk  input  1  system clock (CPU clock domain)
rst  input  1  asynchronous, active-high reset
CPU_MIO  input  1  CPU request valid; held high until MIO_ready is seen
mem_w  input  1  request is a write
addr_bus  input  32  request address
step  input  1  debounced manual-step button (used only with MIO_STEP_EN)
MIO_ready  output  1  one-cycle transfer-complete pulse to CPU
busy  output  1  high while a request is being serviced (WAIT/READY/HOLD)
region  output  2  latched region: 0 RAM, 1 SEG, 2 GPIO, 3 CNT
xfer_cnt  output  16  completed-transfer count, wraps 16'hFFFF->0

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous and active-high. On reset: state=IDLE, MIO_ready=0, busy=0, region=0, xfer_cnt=0, wait counter=0.
- FSM states: IDLE, WAIT, READY, HOLD.
- IDLE: on CPU_MIO==1, latch region (decoded from addr_bus) and mem_w. Load the wait counter with that region's *_WAIT value. Go to WAIT, or go straight to READY if the value is 0.
- WAIT: decrement the counter each cycle. When it reaches 1, go to READY. Total cycles from request edge to MIO_ready = N+1 for region wait N.
- READY: MIO_ready=1 for exactly one cycle. xfer_cnt increments in the same cycle. Go to HOLD.
- HOLD: stay while CPU_MIO==1. When CPU_MIO==0, go to IDLE. A new request can start no earlier than the cycle after IDLE is re-entered. Back-to-back requests therefore need at least one CPU_MIO-low cycle.
- Changes on addr_bus or mem_w after latching are ignored until IDLE.
- CPU_MIO dropping in WAIT (aborted request): return to IDLE next cycle. No MIO_ready, no count.
- busy=1 in WAIT, READY, HOLD; busy=0 in IDLE. region holds its latched value until the next request.
- Reset asserted mid-transfer: immediate return to reset values. No MIO_ready is issued.
- Writes and reads use identical latency. mem_w only feeds the optional path below.

Optional Feature:
MIO_STEP_EN.
- Defined: after WAIT expires, the FSM enters a STEP state and holds there until a rising edge of step. The edge detector is a registered previous-step flop, reset to 0. READY is entered on the cycle after the edge. An edge seen during WAIT is ignored. CPU_MIO dropping in STEP aborts to IDLE. busy=1 in STEP.
- Undefined: step is unused; there is no STEP state; latency is as above.

Decomposition:
- Shared package mio_pkg:
  - region encoding constants REG_RAM=0, REG_SEG=1, REG_GPIO=2, REG_CNT=3
  - FSM state encodings
  - base nibbles 4'hE and 4'hF
- One sub-module is natural: mio_region_dec, a combinational addr_bus -> region plus wait-count lookup. It is reusable by MIO_BUS decode.

Test Plan:
- Reset, then RAM read at addr 0x00000010 with CPU_MIO raised at cycle 0 -> MIO_ready high only at cycle 3 (RAM_WAIT=2); region=0; xfer_cnt=1.
- Counter write at 0xF0000004 -> MIO_ready at cycle 4, region=3. LED write at 0xF0000000 -> MIO_ready at cycle 2, region=2. 7-seg write at 0xE0000000 -> MIO_ready at cycle 2, region=1.
- Request held high 5 cycles after MIO_ready -> exactly one MIO_ready pulse; busy stays 1 until CPU_MIO falls; second request accepted only after one low cycle.
- Aborts:
  - CPU_MIO dropped in WAIT of a RAM access -> no MIO_ready, xfer_cnt unchanged, IDLE next cycle.
  - rst pulsed mid-WAIT -> all outputs 0 asynchronously.
- xfer_cnt preloaded to 0xFFFF via 65535 transfers, plus one more -> wraps to 0x0000.
- With MIO_STEP_EN:
  - RAM access, step edge at cycle 10 -> MIO_ready at cycle 11.
  - Step edge during WAIT only -> no MIO_ready.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared encodings for the MIO wait-state controller: region codes, address base
// nibbles, FSM state constants and the address-to-region decode helper.
package mio_pkg;

  typedef logic [1:0] region_t;

  localparam region_t REG_RAM  = 2'd0;
  localparam region_t REG_SEG  = 2'd1;
  localparam region_t REG_GPIO = 2'd2;
  localparam region_t REG_CNT  = 2'd3;

  localparam logic [3:0] BASE_SEG = 4'hE;
  localparam logic [3:0] BASE_IO  = 4'hF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_READY = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_STEP  = 3'd4;

  // IO page splits on addr[2]: LED/GPIO at offset 0, counter at offset 4.
  function automatic region_t region_of_addr(input logic [31:0] addr);
    if (addr[31:28] == BASE_SEG) return REG_SEG;
    if (addr[31:28] == BASE_IO)  return addr[2] ? REG_CNT : REG_GPIO;
    return REG_RAM;
  endfunction

endpackage

// File: rtl/mio_region_dec.sv
// Combinational MIO address decode: region code plus that region's wait-cycle count.
module mio_region_dec
  import mio_pkg::*;
#(
  parameter int unsigned RAM_WAIT  = 2,
  parameter int unsigned SEG_WAIT  = 1,
  parameter int unsigned GPIO_WAIT = 1,
  parameter int unsigned CNT_WAIT  = 3
) (
  input  logic [31:0] i_addr,
  output logic [1:0]  o_region,
  output logic [3:0]  o_wait
);

  always_comb begin
    o_region = region_of_addr(i_addr);
    o_wait   = 4'(RAM_WAIT);
    unique case (o_region)
      REG_RAM:  o_wait = 4'(RAM_WAIT);
      REG_SEG:  o_wait = 4'(SEG_WAIT);
      REG_GPIO: o_wait = 4'(GPIO_WAIT);
      REG_CNT:  o_wait = 4'(CNT_WAIT);
      default:  o_wait = 4'(RAM_WAIT);
    endcase
  end

endmodule

// File: rtl/mio_wait_ctrl.sv
// MIO bus wait-state controller: region-dependent wait cycles, then a one-cycle MIO_ready.
// Define MIO_STEP_EN to gate each completion on a rising edge of the manual step button.
module mio_wait_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned RAM_WAIT  = 2,
  parameter int unsigned SEG_WAIT  = 1,
  parameter int unsigned GPIO_WAIT = 1,
  parameter int unsigned CNT_WAIT  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] addr_bus,
  input  logic        step,
  output logic        MIO_ready,
  output logic        busy,
  output logic [1:0]  region,
  output logic [15:0] xfer_cnt
);

`ifdef MIO_STEP_EN
  localparam logic [2:0] ST_EXPIRED = ST_STEP;
`else
  localparam logic [2:0] ST_EXPIRED = ST_READY;
`endif

  logic [2:0]  r_state, w_state_d;
  logic [3:0]  r_wait, w_wait_d;
  region_t     r_region, w_region_d;
  logic        r_mem_w, w_mem_w_d;
  logic [15:0] r_xfer_cnt, w_xfer_cnt_d;
  region_t     w_dec_region;
  logic [3:0]  w_dec_wait;
  logic        w_step_rise;
  logic        w_unused;

  mio_region_dec #(
    .RAM_WAIT  (RAM_WAIT),
    .SEG_WAIT  (SEG_WAIT),
    .GPIO_WAIT (GPIO_WAIT),
    .CNT_WAIT  (CNT_WAIT)
  ) u_region_dec (
    .i_addr   (addr_bus),
    .o_region (w_dec_region),
    .o_wait   (w_dec_wait)
  );

`ifdef MIO_STEP_EN
  logic r_step_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_step_prev <= 1'b0;
    else     r_step_prev <= step;
  end

  assign w_step_rise = step & ~r_step_prev;
  assign w_unused    = r_mem_w;
`else
  assign w_step_rise = 1'b0;
  assign w_unused    = ^{step, r_mem_w, w_step_rise};
`endif

  always_comb begin
    w_state_d  = r_state;
    w_wait_d   = r_wait;
    w_region_d = r_region;
    w_mem_w_d  = r_mem_w;
    case (r_state)
      ST_IDLE: begin
        if (CPU_MIO) begin
          w_region_d = w_dec_region;
          w_mem_w_d  = mem_w;
          w_wait_d   = w_dec_wait;
          w_state_d  = (w_dec_wait == 4'd0) ? ST_EXPIRED : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An abort takes priority over the count expiring in the same cycle.
        if (!CPU_MIO) begin
          w_state_d = ST_IDLE;
          w_wait_d  = 4'd0;
        end else if (r_wait <= 4'd1) begin
          w_state_d = ST_EXPIRED;
          w_wait_d  = 4'd0;
        end else begin
          w_wait_d = r_wait - 4'd1;
        end
      end
      ST_STEP: begin
        if (!CPU_MIO)        w_state_d = ST_IDLE;
        else if (w_step_rise) w_state_d = ST_READY;
      end
      ST_READY: w_state_d = ST_HOLD;
      ST_HOLD: begin
        if (!CPU_MIO) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  // Count on entry to READY so xfer_cnt moves in the same cycle MIO_ready is high.
  assign w_xfer_cnt_d = (w_state_d == ST_READY) ? r_xfer_cnt + 16'd1 : r_xfer_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait     <= 4'd0;
      r_region   <= REG_RAM;
      r_mem_w    <= 1'b0;
      r_xfer_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_d;
      r_wait     <= w_wait_d;
      r_region   <= w_region_d;
      r_mem_w    <= w_mem_w_d;
      r_xfer_cnt <= w_xfer_cnt_d;
    end
  end

  assign MIO_ready = (r_state == ST_READY);
  assign busy      = (r_state != ST_IDLE);
  assign region    = r_region;
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_mio_wait_ctrl.sv
// Self-checking bench for mio_wait_ctrl: vector table, corner sequences and random transfers.
// Expectations adapt to MIO_STEP_EN when the design is built with it.
module tb_mio_wait_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] addr_bus;
  logic        step;
  logic        MIO_ready;
  logic        busy;
  logic [1:0]  region;
  logic [15:0] xfer_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_cnt;

  localparam int NEVER = 1000000;
`ifdef MIO_STEP_EN
  localparam int TBL_STEP_AT = 10;
`else
  localparam int TBL_STEP_AT = 0;
`endif

  always #5 clk = ~clk;

  mio_wait_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .CPU_MIO   (CPU_MIO),
    .mem_w     (mem_w),
    .addr_bus  (addr_bus),
    .step      (step),
    .MIO_ready (MIO_ready),
    .busy      (busy),
    .region    (region),
    .xfer_cnt  (xfer_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  exp_region;
    int          exp_ready;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference rules: region and wait count straight from the address map.
  function automatic int wait_of(input logic [31:0] a);
    logic [3:0] nib;
    nib = a[31:28];
    if (nib == 4'hE) return 1;
    if (nib == 4'hF) return a[2] ? 3 : 1;
    return 2;
  endfunction

  function automatic logic [1:0] region_of(input logic [31:0] a);
    logic [3:0] nib;
    nib = a[31:28];
    if (nib == 4'hE) return 2'd1;
    if (nib == 4'hF) return a[2] ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  // Cycle at which MIO_ready is due, counting cycle 0 as the one CPU_MIO is raised in;
  // s is the cycle step is raised in (only meaningful with MIO_STEP_EN).
  function automatic int ready_cycle(input logic [31:0] a, input int s);
    int n;
    n = wait_of(a);
`ifdef MIO_STEP_EN
    return (s >= n + 1) ? s + 1 : NEVER;
`else
    return (s >= 0) ? n + 1 : n + 1;
`endif
  endfunction

  // One request: raised now (DUT idle), dropped in cycle d, step raised in cycle s.
  task automatic run_txn(input logic [31:0] a, input logic w, input int d, input int s,
                         input string tag);
    int r;
    int last_busy;
    bit done;
    r         = ready_cycle(a, s);
    done      = (d >= r);
    last_busy = (d == r) ? d + 1 : d;
    CPU_MIO   = 1'b1;
    addr_bus  = a;
    mem_w     = w;
    step      = 1'b0;
    for (int c = 1; c <= last_busy + 1; c++) begin
      tick;
      if (done && c == r) m_cnt++;
      chk({tag, ".ready"}, {31'd0, MIO_ready}, {31'd0, (done && c == r)});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, (c <= last_busy)});
      chk({tag, ".region"}, {30'd0, region}, {30'd0, region_of(a)});
      chk({tag, ".xfer_cnt"}, {16'd0, xfer_cnt}, {16'd0, m_cnt});
      addr_bus = $urandom;
      mem_w    = 1'($urandom);
      if (c == d) CPU_MIO = 1'b0;
      if (c == s) step = 1'b1;
    end
    step = 1'b0;
  endtask

  vec_t tbl[4];

  initial begin
    int r;
    tbl[0] = '{32'h0000_0010, 1'b0, 2'd0, 3};
    tbl[1] = '{32'hF000_0004, 1'b1, 2'd3, 4};
    tbl[2] = '{32'hF000_0000, 1'b1, 2'd2, 2};
    tbl[3] = '{32'hE000_0000, 1'b1, 2'd1, 2};
`ifdef MIO_STEP_EN
    for (int i = 0; i < 4; i++) tbl[i].exp_ready = TBL_STEP_AT + 1;
`endif

    rst      = 1'b1;
    CPU_MIO  = 1'b0;
    mem_w    = 1'b0;
    addr_bus = 32'd0;
    step     = 1'b0;
    m_cnt    = 16'd0;
    tick;
    tick;
    chk("reset.ready", {31'd0, MIO_ready}, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.region", {30'd0, region}, 32'd0);
    chk("reset.xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    rst = 1'b0;
    tick;

    // Vector table: drop CPU_MIO in the cycle MIO_ready is seen.
    for (int i = 0; i < 4; i++) begin
      CPU_MIO  = 1'b1;
      addr_bus = tbl[i].addr;
      mem_w    = tbl[i].wr;
      for (int c = 1; c <= tbl[i].exp_ready + 2; c++) begin
        tick;
        chk($sformatf("tbl%0d.ready@%0d", i, c), {31'd0, MIO_ready},
            {31'd0, (c == tbl[i].exp_ready)});
        chk($sformatf("tbl%0d.busy@%0d", i, c), {31'd0, busy},
            {31'd0, (c <= tbl[i].exp_ready + 1)});
        if (c == tbl[i].exp_ready) begin
          m_cnt++;
          chk($sformatf("tbl%0d.region", i), {30'd0, region}, {30'd0, tbl[i].exp_region});
          chk($sformatf("tbl%0d.xfer_cnt", i), {16'd0, xfer_cnt}, {16'd0, m_cnt});
          CPU_MIO = 1'b0;
        end
        addr_bus = $urandom;
        if (c == TBL_STEP_AT) step = 1'b1;
      end
      step = 1'b0;
    end

    // Held five cycles past MIO_ready, then an immediate second request.
    r = ready_cycle(32'h0000_0100, 10);
    run_txn(32'h0000_0100, 1'b0, (r == NEVER) ? 12 : r + 5, 10, "hold5");
    run_txn(32'hF000_0000, 1'b1, (ready_cycle(32'hF000_0000, 5) == NEVER) ? 8 :
            ready_cycle(32'hF000_0000, 5) + 1, 5, "b2b");

    // Abort in the middle of a RAM wait.
    run_txn(32'h0000_0020, 1'b0, 1, 10, "abort_wait");
    run_txn(32'h1234_5678, 1'b0, 2, 10, "abort_last");

    // Step edge only while still waiting: must never complete with step gating.
    run_txn(32'h0000_0030, 1'b0, 8, 1, "step_early");
    run_txn(32'h0000_0040, 1'b0, 12, 10, "step_at10");

    // Reset pulsed mid-WAIT clears everything without a clock edge.
    CPU_MIO  = 1'b1;
    addr_bus = 32'hF000_0004;
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("midrst.ready", {31'd0, MIO_ready}, 32'd0);
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.region", {30'd0, region}, 32'd0);
    chk("midrst.xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    m_cnt = 16'd0;
    CPU_MIO = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("postrst.busy", {31'd0, busy}, 32'd0);
    chk("postrst.ready", {31'd0, MIO_ready}, 32'd0);

    // Randomised transfers against the reference rules.
    for (int k = 0; k < 200; k++) begin
      logic [31:0] a;
      int s;
      int d;
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[31:28] = 4'hE;
      else if ($urandom_range(0, 2) == 0) a[31:28] = 4'hF;
      s = $urandom_range(1, wait_of(a) + 4);
      r = ready_cycle(a, s);
      d = (r == NEVER) ? $urandom_range(1, 10) : $urandom_range(1, r + 3);
      run_txn(a, 1'($urandom), d, s, $sformatf("rnd%0d", k));
    end

    // Counter wrap: jump the count to FFFF, then complete one more transfer.
    force dut.r_xfer_cnt = 16'hFFFF;
    tick;
    release dut.r_xfer_cnt;
    m_cnt = 16'hFFFF;
    tick;
    chk("wrap.preload", {16'd0, xfer_cnt}, 32'h0000_FFFF);
    r = ready_cycle(32'hE000_0000, 4);
    run_txn(32'hE000_0000, 1'b1, (r == NEVER) ? 8 : r + 1, 4, "wrap");
    chk("wrap.zero", {16'd0, xfer_cnt}, {16'd0, m_cnt});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
